// File: rtl/vga_plot_arbiter.sv
// Burst-granular arbiter sharing the vga_adapter pixel-write port between clear, sprite and background streams.
// Optional background starvation promotion is enabled by defining PLOT_ARB_STARVE_EN.
module vga_plot_arbiter #(
  parameter int H_RES        = 320,
  parameter int V_RES        = 240,
  parameter int STARVE_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [2:0]  valid,
  input  logic [2:0]  last,
  input  logic [26:0] px,
  input  logic [23:0] py,
  input  logic [44:0] pcol,
  output logic [2:0]  grant,
  output logic [2:0]  ready,
  output logic [8:0]  vga_x,
  output logic [7:0]  vga_y,
  output logic [14:0] vga_colour,
  output logic        vga_plot,
  output logic        busy,
  output logic [15:0] clip_count
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [9:0]  H_LIM      = 10'(H_RES);
  localparam logic [8:0]  V_LIM      = 9'(V_RES);
  localparam logic [15:0] STARVE_MAX = 16'(STARVE_LIMIT);

  state_t      state, state_n;
  logic [2:0]  grant_n;
  logic [2:0]  winner;
  logic        promote;
  logic        hs, last_hs, owner_req, in_range;
  logic [8:0]  sel_x;
  logic [7:0]  sel_y;
  logic [14:0] sel_col;

  assign ready = grant;
  assign busy  = (state == GRANT);

  // grant is one-hot, so masking with it isolates the owner's handshake and request.
  assign hs        = |(valid & grant);
  assign last_hs   = |(valid & last & grant);
  assign owner_req = |(req & grant);

  always_comb begin
    sel_x   = px[8:0];
    sel_y   = py[7:0];
    sel_col = pcol[14:0];
    if (grant[2]) begin
      sel_x   = px[26:18];
      sel_y   = py[23:16];
      sel_col = pcol[44:30];
    end else if (grant[1]) begin
      sel_x   = px[17:9];
      sel_y   = py[15:8];
      sel_col = pcol[29:15];
    end
  end

  assign in_range = ({1'b0, sel_x} < H_LIM) && ({1'b0, sel_y} < V_LIM);

`ifdef PLOT_ARB_STARVE_EN
  logic [15:0] starve_cnt;

  assign promote = (starve_cnt == STARVE_MAX);

  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (grant_n[2]) begin
      starve_cnt <= '0;
    end else if (req[2] && !grant[2] && (starve_cnt != STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 16'd1;
    end
  end
`else
  logic cfg_unused;

  assign promote    = 1'b0;
  assign cfg_unused = ^STARVE_MAX;
`endif

  always_comb begin
    winner = 3'b000;
    if (req[0])                 winner = 3'b001;
    else if (promote && req[2]) winner = 3'b100;
    else if (req[1])            winner = 3'b010;
    else if (req[2])            winner = 3'b100;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_n = state;
    grant_n = grant;
    unique case (state)
      IDLE: begin
        grant_n = 3'b000;
        if (|req) begin
          grant_n = winner;
          state_n = GRANT;
        end
      end
      GRANT: begin
        // Completion on a last beat, or abort when the owner lets go without a beat.
        if (last_hs || (!owner_req && !hs)) begin
          grant_n = 3'b000;
          state_n = IDLE;
        end
      end
      default: begin
        grant_n = 3'b000;
        state_n = IDLE;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      grant      <= 3'b000;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      clip_count <= '0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      vga_plot <= 1'b0;
      if (hs) begin
        vga_x      <= sel_x;
        vga_y      <= sel_y;
        vga_colour <= sel_col;
        vga_plot   <= in_range;
        if (!in_range && (clip_count != 16'hFFFF)) clip_count <= clip_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Self-checking bench for vga_plot_arbiter: directed bursts with a pixel scoreboard.
module tb_vga_plot_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req, valid, last;
  logic [26:0] px;
  logic [23:0] py;
  logic [44:0] pcol;
  logic [2:0]  grant, ready;
  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  logic [14:0] vga_colour;
  logic        vga_plot, busy;
  logic [15:0] clip_count;

  typedef struct packed {
    logic [8:0]  x;
    logic [7:0]  y;
    logic [14:0] c;
  } pix_t;

  pix_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  vga_plot_arbiter #(.H_RES(320), .V_RES(240), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset(reset), .req(req), .valid(valid), .last(last),
    .px(px), .py(py), .pcol(pcol), .grant(grant), .ready(ready),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .busy(busy), .clip_count(clip_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int i, input int x, input int y, input int c, input logic l);
    pix_t p;
    valid = 3'(1 << i);
    last  = l ? 3'(1 << i) : 3'b000;
    px[9*i +: 9]    = 9'(x);
    py[8*i +: 8]    = 8'(y);
    pcol[15*i +: 15] = 15'(c);
    p.x = 9'(x);
    p.y = 8'(y);
    p.c = 15'(c);
    if (x < 320 && y < 240) exp_q.push_back(p);
  endtask

  task automatic no_beat();
    valid = 3'b000;
    last  = 3'b000;
  endtask

  // Every plotted pixel must match the oldest expected on-screen beat.
  always @(negedge clk) begin
    if (reset === 1'b1 && vga_plot === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_extra_plot", 32'(exp_q.size()), 32'd1);
      end else begin
        check("sb_pixel", {vga_x, vga_y, vga_colour}, exp_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b0;
    req = 3'b111; valid = 3'b000; last = 3'b000;
    px = '0; py = '0; pcol = '0;

    tick(); tick();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_plot", 32'(vga_plot), 32'd0);
    check("rst_pixel", {vga_x, vga_y, vga_colour}, 32'd0);
    check("rst_clip", 32'(clip_count), 32'd0);

    reset = 1'b1;
    tick();
    check("first_grant_clear", 32'(grant), 32'b001);
    check("first_busy", 32'(busy), 32'd1);
    req = 3'b000;
    tick();
    check("abort_no_beat", 32'(grant), 32'd0);

    // Sprite burst of four beats, request held across the end.
    req = 3'b010;
    tick();
    check("sprite_grant", 32'(grant), 32'b010);
    check("sprite_ready", 32'(ready), 32'b010);
    for (int k = 0; k < 4; k++) begin
      beat(1, 100 + k, 50, 15'h7FFF, k == 3);
      tick();
      check("burst_plot", 32'(vga_plot), 32'd1);
      check("burst_grant", 32'(grant), (k == 3) ? 32'd0 : 32'b010);
    end
    no_beat();
    tick();
    check("gap_plot", 32'(vga_plot), 32'd0);
    check("gap_hold_x", 32'(vga_x), 32'd103);
    check("rearb_after_gap", 32'(grant), 32'b010);
    req = 3'b000;
    tick();
    check("rearb_abort", 32'(grant), 32'd0);

    // Contention: sprite first, clear arrives mid-burst without preempting.
    req = 3'b110;
    tick();
    check("cont_sprite_first", 32'(grant), 32'b010);
    beat(1, 200, 10, 15'h001F, 1'b0);
    req = 3'b111;
    tick();
    check("no_preempt", 32'(grant), 32'b010);
    beat(1, 201, 10, 15'h001F, 1'b1);
    tick();
    check("cont_burst_end", 32'(grant), 32'd0);
    no_beat();
    tick();
    check("clear_wins", 32'(grant), 32'b001);
    beat(0, 0, 0, 0, 1'b1);
    req = 3'b110;
    tick();
    check("single_beat_end", 32'(grant), 32'd0);
    no_beat();
    tick();
    check("sprite_over_bg", 32'(grant), 32'b010);
    beat(1, 202, 11, 15'h03E0, 1'b1);
    req = 3'b100;
    tick();
    no_beat();
    tick();
    check("bg_after_idle", 32'(grant), 32'b100);

    // Clipping on the background stream.
    beat(2, 319, 239, 15'h7C00, 1'b0);
    tick();
    check("clip_edge_plot", 32'(vga_plot), 32'd1);
    check("clip_edge_count", 32'(clip_count), 32'd0);
    beat(2, 320, 0, 15'h7C00, 1'b0);
    tick();
    check("clip_x_plot", 32'(vga_plot), 32'd0);
    check("clip_x_count", 32'(clip_count), 32'd1);
    beat(2, 0, 240, 15'h7C00, 1'b1);
    req = 3'b000;
    tick();
    check("clip_y_plot", 32'(vga_plot), 32'd0);
    check("clip_y_count", 32'(clip_count), 32'd2);
    check("clip_burst_end", 32'(grant), 32'd0);
    no_beat();

    // Abort: sprite drops its request after two beats, background waiting.
    req = 3'b110;
    tick();
    check("abort_sprite_grant", 32'(grant), 32'b010);
    beat(1, 50, 60, 15'h1234, 1'b0);
    tick();
    beat(1, 51, 60, 15'h1234, 1'b0);
    tick();
    check("abort_mid_grant", 32'(grant), 32'b010);
    req = 3'b100;
    no_beat();
    tick();
    check("abort_idle", 32'(grant), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    tick();
    check("abort_then_bg", 32'(grant), 32'b100);
    req = 3'b000;
    tick();
    check("bg_abort", 32'(grant), 32'd0);

`ifdef PLOT_ARB_STARVE_EN
    // Background waits through two sprite bursts; the wait count reaches 8 before the third arbitration.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    req = 3'b110;
    for (int b = 0; b < 3; b++) begin
      tick();
      check("starve_arb", 32'(grant), (b < 2) ? 32'b010 : 32'b100);
      if (b < 2) begin
        for (int k = 0; k < 4; k++) begin
          beat(1, 10 + k, 5, 15'h0123, k == 3);
          tick();
        end
        no_beat();
      end
    end
    req = 3'b000;
    tick();
    check("starve_bg_abort", 32'(grant), 32'd0);
`endif

    tick(); tick();
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
